// File: rtl/spi_regs_pkg.sv
// rtl/spi_regs_pkg.sv - shared constants, state encoding and helpers for the SPI register responder
// Purpose: frame geometry, special addresses and FSM state type used by spi_regs_responder.
// Ports: none (package).
package spi_regs_pkg;

  localparam int ADDR_W      = 5;
  localparam int DATA_W      = 8;
  localparam int FRAME_W     = 16;
  localparam int RW_BIT      = 15;
  localparam int SOFTRST_BIT = 5;
  localparam int CNT_W       = $clog2(FRAME_W);

  localparam logic [ADDR_W-1:0] ID_ADDR = 5'h1F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  // A write of this data to this address requests a clear of the whole register file.
  function automatic logic is_softrst(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    return (a == '0) && d[SOFTRST_BIT];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall pulse outputs
// Purpose: bring an asynchronous pin into clk_in and flag its edges for one cycle.
// Ports:
//   clk_in   system clock
//   rst_in   synchronous active-high reset (chain loads RESET_VAL)
//   d_in     asynchronous input
//   sync_out synchronized level
//   rise_out one-cycle pulse on synchronized 0->1
//   fall_out one-cycle pulse on synchronized 1->0
module spi_sync_edge #(
  parameter int   SYNC_FF   = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_in,
  output logic sync_out,
  output logic rise_out,
  output logic fall_out
);

  logic [SYNC_FF-1:0] sync_sr;
  logic               prev;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_sr <= {SYNC_FF{RESET_VAL}};
      prev    <= RESET_VAL;
    end else begin
      sync_sr <= {sync_sr[SYNC_FF-2:0], d_in};
      prev    <= sync_sr[SYNC_FF-1];
    end
  end

  assign sync_out = sync_sr[SYNC_FF-1];
  assign rise_out = sync_out & ~prev;
  assign fall_out = ~sync_out & prev;

endmodule

// File: rtl/spi_regs_responder.sv
// rtl/spi_regs_responder.sv - 3-wire SPI target serving a 32 x 8-bit register file
// Purpose: decodes 16-bit frames [15]=R/W(1=read) [14:13]=ignored [12:8]=addr [7:0]=data,
//   MSB first, CPOL=0; sample on sck rise, drive on sck fall. Address 5'h1F reads ID_VALUE.
// Optional feature macro: SPI_REGS_SOFTRST_EN (write to 5'h00 with data bit 5 set clears all registers).
// Ports:
//   clk_in, rst_in            system clock, synchronous active-high reset
//   spi_scs_in/sck_in/sdio_in asynchronous SPI pins (scs active-low)
//   spi_sdio_out/spi_sdio_oe  SDIO pad data and output enable
//   regs_out                  flat register file, reg k at [8k+7:8k]
//   wr_stb_out/addr/data      one-cycle pulse per completed write plus held address/data
//   busy_out                  synchronized scs low
module spi_regs_responder
  import spi_regs_pkg::*;
#(
  parameter logic [7:0] ID_VALUE = 8'hA5,
  parameter int         SYNC_FF  = 2
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         spi_scs_in,
  input  logic         spi_sck_in,
  input  logic         spi_sdio_in,
  output logic         spi_sdio_out,
  output logic         spi_sdio_oe,
  output logic [255:0] regs_out,
  output logic         wr_stb_out,
  output logic [4:0]   wr_addr_out,
  output logic [7:0]   wr_data_out,
  output logic         busy_out
);

  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_W - 1);

  logic scs_sync, scs_rise, scs_fall;
  logic sck_level_unused, sck_rise, sck_fall;
  logic [SYNC_FF-1:0] sdio_sr;
  logic sdio_sync;

  // scs idles high, so its chain resets to 1 to avoid a phantom frame start.
  spi_sync_edge #(.SYNC_FF(SYNC_FF), .RESET_VAL(1'b1)) u_scs_sync (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .d_in    (spi_scs_in),
    .sync_out(scs_sync),
    .rise_out(scs_rise),
    .fall_out(scs_fall)
  );

  // Only sck edges matter; its level is not used.
  spi_sync_edge #(.SYNC_FF(SYNC_FF), .RESET_VAL(1'b0)) u_sck_sync (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .d_in    (spi_sck_in),
    .sync_out(sck_level_unused),
    .rise_out(sck_rise),
    .fall_out(sck_fall)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) sdio_sr <= '0;
    else        sdio_sr <= {sdio_sr[SYNC_FF-2:0], spi_sdio_in};
  end
  assign sdio_sync = sdio_sr[SYNC_FF-1];

  state_t             state, state_next;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DATA_W-2:0]  shift_reg;
  logic [DATA_W-1:0]  rx_byte;
  logic               rw;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  rd_sr;
  logic [255:0]       regs_q;
  logic               scs_blocked;
  logic               frame_start;
  logic               sdio_out_q, sdio_oe_q, wr_stb_q;
  logic [ADDR_W-1:0]  wr_addr_q;
  logic [DATA_W-1:0]  wr_data_q;
`ifdef SPI_REGS_SOFTRST_EN
  logic               softrst_pend;
`endif

  // Byte completed by the current rise: the seven bits already shifted plus the live pin.
  assign rx_byte = {shift_reg, sdio_sync};

  // After rst_in mid-frame the scs chain refills with 0 and shows a fall; that frame
  // remnant must be ignored until scs is seen high again.
  assign frame_start = scs_fall & ~scs_blocked;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = HDR;
      HDR:     if (sck_rise && bit_cnt == HDR_LAST) state_next = DATA;
      DATA:    if (sck_rise && bit_cnt == DATA_LAST) state_next = DONE;
      default: state_next = state;
    endcase
    if (scs_rise) state_next = IDLE;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bit_cnt     <= '0;
      shift_reg   <= '0;
      rw          <= 1'b0;
      addr        <= '0;
      rd_sr       <= '0;
      regs_q      <= '0;
      scs_blocked <= 1'b1;
      sdio_out_q  <= 1'b0;
      sdio_oe_q   <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
`ifdef SPI_REGS_SOFTRST_EN
      softrst_pend <= 1'b0;
`endif
    end else begin
      wr_stb_q <= 1'b0;
      if (scs_sync) scs_blocked <= 1'b0;
`ifdef SPI_REGS_SOFTRST_EN
      softrst_pend <= 1'b0;
      if (softrst_pend) regs_q <= '0;
`endif
      if (scs_rise) begin
        sdio_oe_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (frame_start) begin
              bit_cnt   <= '0;
              sdio_oe_q <= 1'b0;
            end
          end
          HDR: begin
            if (sck_rise) begin
              shift_reg <= rx_byte[DATA_W-2:0];
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == HDR_LAST) begin
                rw    <= rx_byte[RW_BIT-DATA_W];
                addr  <= rx_byte[ADDR_W-1:0];
                rd_sr <= (rx_byte[ADDR_W-1:0] == ID_ADDR) ? ID_VALUE
                         : regs_q[{rx_byte[ADDR_W-1:0], 3'b000} +: DATA_W];
              end
            end
          end
          DATA: begin
            if (sck_rise) begin
              shift_reg <= rx_byte[DATA_W-2:0];
              bit_cnt   <= bit_cnt + 1'b1;
              if (bit_cnt == DATA_LAST && !rw && addr != ID_ADDR) begin
                regs_q[{addr, 3'b000} +: DATA_W] <= rx_byte;
                wr_stb_q  <= 1'b1;
                wr_addr_q <= addr;
                wr_data_q <= rx_byte;
`ifdef SPI_REGS_SOFTRST_EN
                softrst_pend <= is_softrst(addr, rx_byte);
`endif
              end
            end
            // First fall after the header turns the pad around; later falls advance the byte.
            if (sck_fall && rw) begin
              if (!sdio_oe_q) begin
                sdio_oe_q  <= 1'b1;
                sdio_out_q <= rd_sr[DATA_W-1];
              end else begin
                sdio_out_q <= rd_sr[DATA_W-2];
                rd_sr      <= {rd_sr[DATA_W-2:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_sdio_out = sdio_out_q;
  assign spi_sdio_oe  = sdio_oe_q;
  assign regs_out     = regs_q;
  assign wr_stb_out   = wr_stb_q;
  assign wr_addr_out  = wr_addr_q;
  assign wr_data_out  = wr_data_q;
  assign busy_out     = ~scs_sync;

endmodule

// File: tb/tb_spi_regs_responder.sv
// tb/tb_spi_regs_responder.sv - self-checking bench for spi_regs_responder
// Purpose: drives SPI frames from a vector table plus reset and soft-reset sequences; a
//   write scoreboard checks each wr_stb_out pulse. Honours SPI_REGS_SOFTRST_EN when defined.
// Ports: none (top-level bench).
module tb_spi_regs_responder;

  localparam int HALF = 8;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         spi_scs_in, spi_sck_in, spi_sdio_in;
  logic         spi_sdio_out, spi_sdio_oe;
  logic [255:0] regs_out;
  logic         wr_stb_out;
  logic [4:0]   wr_addr_out;
  logic [7:0]   wr_data_out;
  logic         busy_out;

  int checks   = 0;
  int failures = 0;

  logic [12:0]  exp_q[$];
  logic [12:0]  exp_e;
  logic [255:0] model;

  spi_regs_responder #(.ID_VALUE(8'hA5), .SYNC_FF(2)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .spi_scs_in  (spi_scs_in),
    .spi_sck_in  (spi_sck_in),
    .spi_sdio_in (spi_sdio_in),
    .spi_sdio_out(spi_sdio_out),
    .spi_sdio_oe (spi_sdio_oe),
    .regs_out    (regs_out),
    .wr_stb_out  (wr_stb_out),
    .wr_addr_out (wr_addr_out),
    .wr_data_out (wr_data_out),
    .busy_out    (busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk_in) begin
    if (wr_stb_out) begin
      chk("stb_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        chk("stb_addr", wr_addr_out, exp_e[12:8]);
        chk("stb_data", wr_data_out, exp_e[7:0]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic spi_frame(input logic [15:0] f, input int nbits, input int rst_bit,
                           output logic [7:0] rd, output logic oe_pre, output logic oe_post);
    rd = 8'h00; oe_pre = 1'b0; oe_post = 1'b0;
    spi_scs_in = 1'b0;
    repeat (HALF) @(negedge clk_in);
    chk("busy_in_frame", busy_out, 1'b1);
    for (int i = 0; i < nbits; i++) begin
      spi_sdio_in = f[15-i];
      repeat (HALF) @(negedge clk_in);
      if (i == 7) oe_pre = spi_sdio_oe;
      if (i == 8) oe_post = spi_sdio_oe;
      if (i >= 8) rd[15-i] = spi_sdio_out;
      spi_sck_in = 1'b1;
      if (i == rst_bit) begin
        repeat (4) @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        chk("rst_mid_oe", spi_sdio_oe, 1'b0);
        chk("rst_mid_regs", regs_out, 256'h0);
        @(negedge clk_in);
        rst_in = 1'b0;
      end
      repeat (HALF) @(negedge clk_in);
      spi_sck_in = 1'b0;
    end
    repeat (HALF) @(negedge clk_in);
    spi_scs_in = 1'b1;
    repeat (HALF) @(negedge clk_in);
  endtask

  task automatic post_frame(input string tag, input logic is_rd, input logic [7:0] exp_rd,
                            input logic [7:0] rd, input logic oe_pre, input logic oe_post);
    if (is_rd) begin
      chk({tag, "_oe_before_8th"}, oe_pre, 1'b0);
      chk({tag, "_oe_after_8th"}, oe_post, 1'b1);
      chk({tag, "_rdata"}, rd, exp_rd);
    end
    chk({tag, "_oe_dropped"}, spi_sdio_oe, 1'b0);
    chk({tag, "_busy_idle"}, busy_out, 1'b0);
    chk({tag, "_stb_pending"}, exp_q.size(), 0);
    chk({tag, "_regs"}, regs_out, model);
  endtask

  task automatic do_write(input string tag, input logic [15:0] f);
    logic [7:0] rd;
    logic oe_pre, oe_post;
    exp_q.push_back(f[12:0]);
    model[{f[12:8], 3'b000} +: 8] = f[7:0];
    spi_frame(f, 16, -1, rd, oe_pre, oe_post);
    post_frame(tag, 1'b0, 8'h00, rd, oe_pre, oe_post);
  endtask

  task automatic do_read(input string tag, input logic [15:0] f, input logic [7:0] exp_rd);
    logic [7:0] rd;
    logic oe_pre, oe_post;
    spi_frame(f, 16, -1, rd, oe_pre, oe_post);
    post_frame(tag, 1'b1, exp_rd, rd, oe_pre, oe_post);
  endtask

  typedef struct {
    logic [15:0] frame;
    int          nbits;
    logic        is_rd;
    logic [7:0]  exp_rd;
    logic        exp_stb;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [7:0] rd;
    logic oe_pre, oe_post;

    vecs[0]  = '{16'h0542, 16, 1'b0, 8'h00, 1'b1};  // write reg5=42
    vecs[1]  = '{16'h8500, 16, 1'b1, 8'h42, 1'b0};  // read it back
    vecs[2]  = '{16'h9F00, 16, 1'b1, 8'hA5, 1'b0};  // ID register
    vecs[3]  = '{16'h1F33, 16, 1'b0, 8'h00, 1'b0};  // write to ID: dropped
    vecs[4]  = '{16'h9F00, 16, 1'b1, 8'hA5, 1'b0};
    vecs[5]  = '{16'h07FF, 10, 1'b0, 8'h00, 1'b0};  // aborted write
    vecs[6]  = '{16'h8700, 16, 1'b1, 8'h00, 1'b0};
    vecs[7]  = '{16'h6755, 16, 1'b0, 8'h00, 1'b1};  // N bits set, addr 7
    vecs[8]  = '{16'hE700, 16, 1'b1, 8'h55, 1'b0};
    vecs[9]  = '{16'h1E3C, 16, 1'b0, 8'h00, 1'b1};
    vecs[10] = '{16'h9E00, 16, 1'b1, 8'h3C, 1'b0};

    model       = '0;
    rst_in      = 1'b1;
    spi_scs_in  = 1'b1;
    spi_sck_in  = 1'b0;
    spi_sdio_in = 1'b0;
    repeat (5) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (4) @(negedge clk_in);

    chk("rst_sdio_out", spi_sdio_out, 1'b0);
    chk("rst_sdio_oe", spi_sdio_oe, 1'b0);
    chk("rst_wr_stb", wr_stb_out, 1'b0);
    chk("rst_wr_addr", wr_addr_out, 5'd0);
    chk("rst_wr_data", wr_data_out, 8'd0);
    chk("rst_busy", busy_out, 1'b0);
    chk("rst_regs", regs_out, 256'h0);

    for (int v = 0; v < 11; v++) begin
      if (vecs[v].exp_stb) begin
        exp_q.push_back(vecs[v].frame[12:0]);
        model[{vecs[v].frame[12:8], 3'b000} +: 8] = vecs[v].frame[7:0];
      end
      spi_frame(vecs[v].frame, vecs[v].nbits, -1, rd, oe_pre, oe_post);
      post_frame($sformatf("vec%0d", v), vecs[v].is_rd, vecs[v].exp_rd, rd, oe_pre, oe_post);
      if (vecs[v].exp_stb) begin
        chk($sformatf("vec%0d_held_addr", v), wr_addr_out, vecs[v].frame[12:8]);
        chk($sformatf("vec%0d_held_data", v), wr_data_out, vecs[v].frame[7:0]);
      end
    end

    // rst_in during the data phase of a read; the frame tail must be ignored.
    spi_frame(16'h8500, 16, 10, rd, oe_pre, oe_post);
    model = '0;
    chk("rst_frame_oe_pre", oe_pre, 1'b0);
    chk("rst_frame_oe_post", oe_post, 1'b1);
    post_frame("after_rst", 1'b0, 8'h00, rd, oe_pre, oe_post);
    chk("after_rst_wr_addr", wr_addr_out, 5'd0);
    do_write("rewrite5", 16'h0542);
    do_read("reread5", 16'h8500, 8'h42);

    // Soft-reset write to address 0.
    exp_q.push_back(13'h0020);
`ifdef SPI_REGS_SOFTRST_EN
    model = '0;
`else
    model[7:0] = 8'h20;
`endif
    spi_frame(16'h0020, 16, -1, rd, oe_pre, oe_post);
    post_frame("softrst_wr", 1'b0, 8'h00, rd, oe_pre, oe_post);
`ifdef SPI_REGS_SOFTRST_EN
    do_read("softrst_rd0", 16'h8000, 8'h00);
    do_read("softrst_rd5", 16'h8500, 8'h00);
`else
    do_read("softrst_rd0", 16'h8000, 8'h20);
    do_read("softrst_rd5", 16'h8500, 8'h42);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
